peripheral_arbiter_wb: RTL and testbench

Round-robin Wishbone arbiter that shares one slave port, typically the GPIO register slave, between NUM_MASTERS bus masters. Arbitration happens only between cycles: once a master is granted, it owns the slave until it drops its cyc, so classic and incrementing bursts are never interrupted. A per-transfer watchdog terminates stalled accesses with an error so a hung slave cannot lock the bus.

---
 rtl/peripheral_arbiter_wb_if.sv | 48 ++++
 rtl/peripheral_arbiter_wb.sv | 138 +++++++++++++
 tb/tb_peripheral_arbiter_wb.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/peripheral_arbiter_wb_if.sv
// Bus bundle for peripheral_arbiter_wb: flattened per-master Wishbone buses plus the shared slave port.
interface peripheral_arbiter_wb_if #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32
);
    logic [NUM_MASTERS*AW-1:0]     m_adr_i;
    logic [NUM_MASTERS*DW-1:0]     m_dat_i;
    logic [NUM_MASTERS*(DW/8)-1:0] m_sel_i;
    logic [NUM_MASTERS-1:0]        m_we_i;
    logic [NUM_MASTERS-1:0]        m_cyc_i;
    logic [NUM_MASTERS-1:0]        m_stb_i;
    logic [NUM_MASTERS*3-1:0]      m_cti_i;
    logic [NUM_MASTERS*2-1:0]      m_bte_i;
    logic [NUM_MASTERS*DW-1:0]     m_dat_o;
    logic [NUM_MASTERS-1:0]        m_ack_o;
    logic [NUM_MASTERS-1:0]        m_err_o;
    logic [NUM_MASTERS-1:0]        m_rty_o;

    logic [AW-1:0]                 s_adr_o;
    logic [DW-1:0]                 s_dat_o;
    logic [DW/8-1:0]               s_sel_o;
    logic                          s_we_o;
    logic                          s_cyc_o;
    logic                          s_stb_o;
    logic [2:0]                    s_cti_o;
    logic [1:0]                    s_bte_o;
    logic [DW-1:0]                 s_dat_i;
    logic                          s_ack_i;
    logic                          s_err_i;
    logic                          s_rty_i;

    // Arbiter view: serves the masters, drives the shared slave port
    modport slave (
        input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
        output m_dat_o, m_ack_o, m_err_o, m_rty_o,
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
        input  s_dat_i, s_ack_i, s_err_i, s_rty_i
    );

    // Environment view: the requesting masters together with the shared slave
    modport master (
        output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
        input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
        input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
        output s_dat_i, s_ack_i, s_err_i, s_rty_i
    );
endinterface

// File: rtl/peripheral_arbiter_wb.sv
// Round-robin Wishbone arbiter sharing one slave between NUM_MASTERS masters.
// Ownership lasts a whole bus cycle; a watchdog errors strobes the slave never terminates.
module peripheral_arbiter_wb #(
    parameter int unsigned DW          = 32,
    parameter int unsigned AW          = 32,
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                   wb_clk,
    input  logic                   wb_rst,
    peripheral_arbiter_wb_if.slave bus,
    output logic [NUM_MASTERS-1:0] grant_o
);
    localparam int unsigned SW   = DW / 8;
    localparam int unsigned LW   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                 state;
    logic [NUM_MASTERS-1:0] grant;
    logic [LW-1:0]          last;
    logic [LW-1:0]          owner;
    logic [LW-1:0]          pick;
    int unsigned            best;
    logic                   busy;
    logic                   owner_cyc;
    logic                   owner_stb;
    logic                   wd_hit;

    assign busy    = (state == BUSY);
    assign grant_o = grant;

    // Round-robin pick: the requester at the smallest distance after last
    always_comb begin
        pick = last;
        best = NUM_MASTERS;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (bus.m_cyc_i[i] &&
                ((i + 2*NUM_MASTERS - 1 - 32'(last)) % NUM_MASTERS) < best) begin
                best = (i + 2*NUM_MASTERS - 1 - 32'(last)) % NUM_MASTERS;
                pick = LW'(i);
            end
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state <= IDLE;
            grant <= '0;
            last  <= LW'(NUM_MASTERS - 1);
            owner <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.m_cyc_i) begin
                        state <= BUSY;
                        grant <= NUM_MASTERS'(1) << pick;
                        owner <= pick;
                    end
                end
                BUSY: begin
                    if (!owner_cyc) begin
                        state <= IDLE;
                        grant <= '0;
                        last  <= owner;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Owner's request fields onto the slave port
    always_comb begin
        owner_cyc   = 1'b0;
        owner_stb   = 1'b0;
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_sel_o = '0;
        bus.s_we_o  = 1'b0;
        bus.s_cti_o = '0;
        bus.s_bte_o = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (busy && owner == LW'(i)) begin
                owner_cyc   = bus.m_cyc_i[i];
                owner_stb   = bus.m_stb_i[i];
                bus.s_adr_o = bus.m_adr_i[i*AW +: AW];
                bus.s_dat_o = bus.m_dat_i[i*DW +: DW];
                bus.s_sel_o = bus.m_sel_i[i*SW +: SW];
                bus.s_we_o  = bus.m_we_i[i];
                bus.s_cti_o = bus.m_cti_i[i*3 +: 3];
                bus.s_bte_o = bus.m_bte_i[i*2 +: 2];
            end
        end
    end

    assign bus.s_cyc_o = owner_cyc;
    assign bus.s_stb_o = owner_stb & ~wd_hit;

    // Slave responses go to the owner only; a watchdog hit replaces them with err
    always_comb begin
        bus.m_dat_o = '0;
        bus.m_ack_o = '0;
        bus.m_err_o = '0;
        bus.m_rty_o = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (busy && owner == LW'(i)) begin
                bus.m_dat_o[i*DW +: DW] = bus.s_dat_i;
                bus.m_ack_o[i]          = bus.s_ack_i & ~wd_hit;
                bus.m_err_o[i]          = bus.s_err_i | wd_hit;
                bus.m_rty_o[i]          = bus.s_rty_i & ~wd_hit;
            end
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_wd
            logic [WD_W-1:0] wd_cnt;
            logic            stall;

            assign stall  = bus.s_stb_o & ~(bus.s_ack_i | bus.s_err_i | bus.s_rty_i);
            assign wd_hit = busy && (wd_cnt == WD_W'(TIMEOUT));

            // Counts consecutive unterminated strobe cycles; the hit clears it before it can wrap
            always_ff @(posedge wb_clk) begin
                if (wb_rst || !busy || wd_hit || !stall) begin
                    wd_cnt <= '0;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end
        end else begin : g_no_wd
            assign wd_hit = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_peripheral_arbiter_wb.sv
// Self-checking bench for peripheral_arbiter_wb: directed scenarios plus random traffic,
// every cycle compared against a behavioural arbitration model.
module tb_peripheral_arbiter_wb;
    localparam int unsigned N  = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TO = 8;

    logic         wb_clk = 1'b0;
    logic         wb_rst;
    logic [N-1:0] grant_o;

    peripheral_arbiter_wb_if #(.NUM_MASTERS(N), .AW(AW), .DW(DW)) bus ();

    peripheral_arbiter_wb #(.DW(DW), .AW(AW), .NUM_MASTERS(N), .TIMEOUT(TO)) dut (
        .wb_clk (wb_clk),
        .wb_rst (wb_rst),
        .bus    (bus),
        .grant_o(grant_o)
    );

    always #5 wb_clk = ~wb_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: owner index (-1 when idle), previous owner, stalled-strobe count
    int mo_owner;
    int mo_last;
    int mo_wd;

    // Slave responder: 0 random, 1 ack after resp_wait wait states, 2 never respond
    int resp_mode;
    int resp_wait;
    int wait_cnt;

    logic [N-1:0] obs_ack, obs_err, obs_grant, prev_grant;
    logic         obs_scyc, obs_sstb;
    int           ack_cnt[N];
    int           err_cnt[N];
    int           stb_cnt;
    logic [63:0]  gseq;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0; bus.m_we_i = '0;
        bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_cti_i = '0; bus.m_bte_i = '0;
        bus.s_dat_i = '0; bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) begin
            ack_cnt[i] = 0;
            err_cnt[i] = 0;
        end
        stb_cnt = 0;
        gseq    = '0;
    endtask

    task automatic drive_slave();
        int unsigned r;
        bus.s_dat_i = $urandom;
        bus.s_ack_i = 1'b0;
        bus.s_err_i = 1'b0;
        bus.s_rty_i = 1'b0;
        if (resp_mode == 0) begin
            r = $urandom_range(0, 15);
            bus.s_ack_i = (r == 0);
            bus.s_err_i = (r == 1);
            bus.s_rty_i = (r == 2);
        end else if (resp_mode == 1) begin
            bus.s_ack_i = bus.s_stb_o && (wait_cnt >= resp_wait);
        end
    endtask

    // One clock: respond, compare at negedge against the model, advance the model at posedge
    task automatic step();
        int              o;
        logic            busy, hit, stall;
        logic [N-1:0]    e_grant, e_ack, e_err, e_rty;
        logic [N*DW-1:0] e_mdat;
        logic            e_cyc, e_stb, e_we;
        logic [AW-1:0]   e_adr;
        logic [DW-1:0]   e_dat;
        logic [SW-1:0]   e_sel;
        logic [2:0]      e_cti;
        logic [1:0]      e_bte;
        #1;
        drive_slave();
        #1;
        @(negedge wb_clk);
        o    = mo_owner;
        busy = (o >= 0);
        hit  = busy && (mo_wd == int'(TO));
        e_grant = '0; e_ack = '0; e_err = '0; e_rty = '0; e_mdat = '0;
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0;
        e_sel = '0; e_cti = '0; e_bte = '0;
        if (busy) begin
            e_grant[o]            = 1'b1;
            e_cyc                 = bus.m_cyc_i[o];
            e_stb                 = bus.m_stb_i[o] && !hit;
            e_we                  = bus.m_we_i[o];
            e_adr                 = bus.m_adr_i[o*AW +: AW];
            e_dat                 = bus.m_dat_i[o*DW +: DW];
            e_sel                 = bus.m_sel_i[o*SW +: SW];
            e_cti                 = bus.m_cti_i[o*3 +: 3];
            e_bte                 = bus.m_bte_i[o*2 +: 2];
            e_ack[o]              = bus.s_ack_i && !hit;
            e_err[o]              = bus.s_err_i || hit;
            e_rty[o]              = bus.s_rty_i && !hit;
            e_mdat[o*DW +: DW]    = bus.s_dat_i;
        end
        check("grant",  64'(grant_o),     64'(e_grant));
        check("s_cyc",  64'(bus.s_cyc_o), 64'(e_cyc));
        check("s_stb",  64'(bus.s_stb_o), 64'(e_stb));
        check("s_adr",  64'(bus.s_adr_o), 64'(e_adr));
        check("s_dat",  64'(bus.s_dat_o), 64'(e_dat));
        check("s_ctl",  64'({bus.s_we_o, bus.s_sel_o, bus.s_cti_o, bus.s_bte_o}),
                        64'({e_we, e_sel, e_cti, e_bte}));
        check("m_ack",  64'(bus.m_ack_o), 64'(e_ack));
        check("m_err",  64'(bus.m_err_o), 64'(e_err));
        check("m_rty",  64'(bus.m_rty_o), 64'(e_rty));
        check("m_dat",  64'(bus.m_dat_o), 64'(e_mdat));

        obs_ack   = bus.m_ack_o;
        obs_err   = bus.m_err_o;
        obs_grant = grant_o;
        obs_scyc  = bus.s_cyc_o;
        obs_sstb  = bus.s_stb_o;
        for (int i = 0; i < N; i++) begin
            ack_cnt[i] += int'(obs_ack[i]);
            err_cnt[i] += int'(obs_err[i]);
            if (grant_o[i] && prev_grant == '0) gseq = (gseq << 4) | 64'(i + 1);
        end
        stb_cnt   += int'(obs_sstb);
        prev_grant = grant_o;

        @(posedge wb_clk);
        if (wb_rst) begin
            mo_owner = -1;
            mo_last  = N - 1;
            mo_wd    = 0;
        end else if (!busy) begin
            mo_wd = 0;
            for (int k = 1; k <= N; k++) begin
                if (mo_owner < 0 && bus.m_cyc_i[(mo_last + k) % N]) mo_owner = (mo_last + k) % N;
            end
        end else begin
            stall = e_stb && !(bus.s_ack_i || bus.s_err_i || bus.s_rty_i);
            mo_wd = (hit || !stall) ? 0 : mo_wd + 1;
            if (!bus.m_cyc_i[o]) begin
                mo_last  = o;
                mo_owner = -1;
                mo_wd    = 0;
            end
        end
        wait_cnt = (obs_sstb && !bus.s_ack_i) ? wait_cnt + 1 : 0;
        #1;
    endtask

    task automatic raise(input int i, input int blen);
        bus.m_cyc_i[i]          = 1'b1;
        bus.m_stb_i[i]          = 1'b1;
        bus.m_we_i[i]           = 1'($urandom);
        bus.m_adr_i[i*AW +: AW] = $urandom & 32'hFFFF_FFFC;
        bus.m_dat_i[i*DW +: DW] = $urandom;
        bus.m_sel_i[i*SW +: SW] = '1;
        bus.m_cti_i[i*3 +: 3]   = (blen > 1) ? 3'b010 : 3'b000;
        bus.m_bte_i[i*2 +: 2]   = 2'b00;
    endtask

    task automatic drop(input int i);
        bus.m_cyc_i[i] = 1'b0;
        bus.m_stb_i[i] = 1'b0;
    endtask

    // Each master runs n[i] cycles of blen beats, re-requesting right after each release
    task automatic run_masters(input string tag, input int n0, input int n1,
                               input int blen, input int budget);
        int rem[N];
        int beat[N];
        int c;
        rem[0] = n0; rem[1] = n1;
        beat[0] = 0; beat[1] = 0;
        gseq = '0;
        c = 0;
        while ((rem[0] > 0 || rem[1] > 0 || bus.m_cyc_i != '0) && c < budget) begin
            for (int i = 0; i < N; i++) begin
                if (bus.m_cyc_i[i]) begin
                    if (obs_ack[i] || obs_err[i]) begin
                        beat[i]++;
                        if (beat[i] == blen || obs_err[i]) begin
                            drop(i);
                            rem[i]--;
                            beat[i] = 0;
                        end else begin
                            bus.m_adr_i[i*AW +: AW] = bus.m_adr_i[i*AW +: AW] + 32'd4;
                            bus.m_dat_i[i*DW +: DW] = $urandom;
                            bus.m_cti_i[i*3 +: 3]   = (beat[i] == blen - 1) ? 3'b111 : 3'b010;
                        end
                    end
                end else if (rem[i] > 0) begin
                    raise(i, blen);
                end
            end
            step();
            c++;
        end
        check({tag, "_done"}, 64'(c < budget), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int done;
        clear_inputs();
        clear_counts();
        resp_mode  = 1;
        resp_wait  = 0;
        wait_cnt   = 0;
        obs_ack    = '0;
        obs_err    = '0;
        prev_grant = '0;
        wb_rst     = 1'b1;
        repeat (2) @(posedge wb_clk);
        #1;
        mo_owner = -1;
        mo_last  = N - 1;
        mo_wd    = 0;
        step();
        check("reset_grant", 64'(obs_grant), 64'd0);
        check("reset_scyc",  64'(obs_scyc),  64'd0);
        wb_rst = 1'b0;

        // Single master write with two wait states
        clear_counts();
        resp_wait = 2;
        bus.m_cyc_i[1] = 1'b1; bus.m_stb_i[1] = 1'b1; bus.m_we_i[1] = 1'b1;
        bus.m_adr_i[AW +: AW] = 32'h0000_0004;
        bus.m_dat_i[DW +: DW] = 32'hA5A5_0001;
        bus.m_sel_i[SW +: SW] = '1;
        done = 0;
        for (int c = 0; c < 12 && done == 0; c++) begin
            step();
            if (c == 1) check("s1_grant", 64'(obs_grant), 64'b10);
            if (obs_ack[1]) begin
                done = 1;
                drop(1);
            end
        end
        step();
        step();
        check("s1_done", 64'(done),       64'd1);
        check("s1_ack1", 64'(ack_cnt[1]), 64'd1);
        check("s1_ack0", 64'(ack_cnt[0]), 64'd0);

        // Simultaneous requests straight after reset
        resp_wait = 0;
        wb_rst = 1'b1;
        step();
        step();
        wb_rst = 1'b0;
        run_masters("s2", 1, 1, 1, 40);
        check("s2_order", gseq, 64'h12);

        // Fairness across six single-beat cycles
        run_masters("s3", 3, 3, 1, 80);
        check("s3_order", gseq, 64'h121212);

        // Four-beat bursts are never split
        clear_counts();
        resp_wait = 1;
        run_masters("s4", 1, 1, 4, 80);
        check("s4_order", gseq,       64'h12);
        check("s4_ack0",  ack_cnt[0], 64'd4);
        check("s4_ack1",  ack_cnt[1], 64'd4);

        // Watchdog against a slave that never answers
        clear_counts();
        resp_mode = 2;
        run_masters("s5", 1, 0, 1, 40);
        check("s5_err0",  64'(err_cnt[0]), 64'd1);
        check("s5_stb",   64'(stb_cnt),    64'd8);
        check("s5_ack0",  64'(ack_cnt[0]), 64'd0);

        // Reset during the second beat of a burst
        resp_mode = 1;
        resp_wait = 0;
        raise(0, 4);
        done = 0;
        for (int c = 0; c < 10 && done == 0; c++) begin
            step();
            if (obs_ack[0]) done = 1;
        end
        check("s6_beat1", 64'(done), 64'd1);
        bus.m_adr_i[0 +: AW] = bus.m_adr_i[0 +: AW] + 32'd4;
        wb_rst = 1'b1;
        step();
        wb_rst = 1'b0;
        drop(0);
        step();
        check("s6_grant", 64'(obs_grant), 64'd0);
        check("s6_scyc",  64'(obs_scyc),  64'd0);
        run_masters("s6", 1, 1, 1, 40);
        check("s6_order", gseq, 64'h12);

        // Random traffic with random slave responses and occasional resets
        resp_mode = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (bus.m_cyc_i[i]) begin
                    if ($urandom_range(0, 15) == 0) bus.m_cyc_i[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    bus.m_cyc_i[i] = 1'b1;
                end
                bus.m_stb_i[i]          = ($urandom_range(0, 7) != 0);
                bus.m_we_i[i]           = 1'($urandom);
                bus.m_adr_i[i*AW +: AW] = $urandom;
                bus.m_dat_i[i*DW +: DW] = $urandom;
                bus.m_sel_i[i*SW +: SW] = SW'($urandom);
                bus.m_cti_i[i*3 +: 3]   = 3'($urandom);
                bus.m_bte_i[i*2 +: 2]   = 2'($urandom);
            end
            wb_rst = ($urandom_range(0, 299) == 0);
            step();
        end
        wb_rst = 1'b0;
        clear_inputs();
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
